// File: rtl/freq_meter_pkg.sv
// Shared definitions for the 2-digit frequency meter.
//   SEG_BLANK / SEG_DIGIT : segment codes {a,b,c,d,e,f,g}, active-high
//   PHASE_ONES / PHASE_TENS : display scan phase encoding
//   conv_state_e : binary-to-BCD conversion FSM states
//   sat99() : clamps an edge count to the displayable range
package freq_meter_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   localparam logic PHASE_ONES = 1'b0;
   localparam logic PHASE_TENS = 1'b1;

   localparam logic [6:0] MAX_SHOWN = 7'd99;
   localparam logic [6:0] CNT_SAT   = 7'd100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } conv_state_e;

   function automatic logic [6:0] sat99(input logic [6:0] cnt);
      return (cnt > MAX_SHOWN) ? MAX_SHOWN : cnt;
   endfunction

endpackage

// File: rtl/freq_meter_2d_if.sv
// Signal bundle between the frequency meter and its environment.
//   sig_in   : measured square wave (async to clk)
//   display  : segments {a..g}, active-high
//   enable   : one-hot digit enable, bit 0 = ones, bit 1 = tens
//   valid    : one-cycle pulse when new digits are loaded
//   overflow : last window counted more than 99 edges
//   freq_bin : last measured count, saturated at 99
// slave modport is the meter side, master modport the environment side.
interface freq_meter_2d_if;

   logic       sig_in;
   logic [6:0] display;
   logic [1:0] enable;
   logic       valid;
   logic       overflow;
   logic [6:0] freq_bin;

   modport slave (
      input  sig_in,
      output display, enable, valid, overflow, freq_bin
   );

   modport master (
      output sig_in,
      input  display, enable, valid, overflow, freq_bin
   );

endinterface

// File: rtl/seg7_decoder.sv
// BCD to 7-segment decoder.
//   bcd : 4-bit digit; codes 10..15 produce a blank digit
//   seg : segments {a,b,c,d,e,f,g}, active-high
module seg7_decoder
   import freq_meter_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) begin
         seg = SEG_DIGIT[bcd];
      end
   end

endmodule

// File: rtl/freq_meter_2d.sv
// 2-digit frequency meter: counts rising edges of bus.sig_in over a gate
// window of GATE_CYCLES clk cycles, converts the saturated count to BCD
// by repeated subtraction of 10, and scans both digits onto a shared
// 7-segment bus.
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : freq_meter_2d_if.slave (sig_in in; display, enable, valid,
//         overflow, freq_bin out)
// Optional build macro LEADING_ZERO_BLANK_EN: blanks the tens digit when it
// is zero (enable sequence unchanged).
//
// Conversion FSM
//   state | meaning
//   IDLE  | wait for gate_end, then seed rem with the saturated snapshot
//   CONV  | subtract 10 from rem per cycle, counting tens
//   LOAD  | copy tens/rem into the digit registers, pulse valid
module freq_meter_2d
   import freq_meter_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 27_000_000,
   parameter int unsigned GATE_CYCLES = 27_000_000,
   parameter int unsigned SCAN_DIV    = 225_000
) (
   input  logic            clk,
   input  logic            rst,
   freq_meter_2d_if.slave  bus
);

   localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   // The conversion of 99 takes 11 cycles; a shorter gate would let the
   // next gate_end arrive before the FSM is back in IDLE.
   if (GATE_CYCLES < 16 || SCAN_DIV < 1 || CLK_HZ < 4) begin : g_param_check
      $error("freq_meter_2d: need GATE_CYCLES >= 16, SCAN_DIV >= 1, CLK_HZ >= 4");
   end

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            sync3_q, sync3_d;
   logic            edge_q, edge_d;
   logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
   logic [6:0]      edge_cnt_q, edge_cnt_d;
   logic            ovf_q, ovf_d;
   logic [6:0]      freq_bin_q, freq_bin_d;
   logic            overflow_q, overflow_d;
   conv_state_e     state_q, state_d;
   logic [6:0]      rem_q, rem_d;
   logic [3:0]      tens_q, tens_d;
   logic [3:0]      digit_ones_q, digit_ones_d;
   logic [3:0]      digit_tens_q, digit_tens_d;
   logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
   logic            phase_q, phase_d;

   logic            gate_end;
   logic [6:0]      cnt_incl;
   logic            ovf_incl;
   logic [6:0]      snap_sat;
   logic            valid;
   logic [1:0]      enable;
   logic [3:0]      shown_digit;
   logic [6:0]      seg;

   // Two-flop synchronizer, then a registered rising-edge detector.
   always_comb begin
      sync1_d = bus.sig_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      edge_d  = sync2_q & ~sync3_q;
   end

   // cnt_incl already contains an edge seen on this cycle, so an edge on the
   // gate_end cycle lands in the closing window and the counter can restart
   // from zero on the next cycle without dropping anything.
   always_comb begin
      gate_end   = (gate_cnt_q == GATE_LAST);
      gate_cnt_d = gate_end ? '0 : gate_cnt_q + GW'(1);

      cnt_incl = edge_cnt_q;
      if (edge_q && (edge_cnt_q != CNT_SAT)) begin
         cnt_incl = edge_cnt_q + 7'd1;
      end
      ovf_incl = ovf_q | (cnt_incl > MAX_SHOWN);
      snap_sat = sat99(cnt_incl);

      edge_cnt_d = gate_end ? '0 : cnt_incl;
      ovf_d      = gate_end ? 1'b0 : ovf_incl;
      freq_bin_d = gate_end ? snap_sat : freq_bin_q;
      overflow_d = gate_end ? ovf_incl : overflow_q;
   end

   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         IDLE:    if (gate_end) state_d = CONV;
         CONV:    if (rem_q < 7'd10) state_d = LOAD;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : fsm_out
      rem_d        = rem_q;
      tens_d       = tens_q;
      digit_ones_d = digit_ones_q;
      digit_tens_d = digit_tens_q;
      valid        = 1'b0;
      case (state_q)
         IDLE: begin
            if (gate_end) begin
               rem_d  = snap_sat;
               tens_d = '0;
            end
         end
         CONV: begin
            if (rem_q >= 7'd10) begin
               rem_d  = rem_q - 7'd10;
               tens_d = tens_q + 4'd1;
            end
         end
         LOAD: begin
            digit_tens_d = tens_q;
            digit_ones_d = rem_q[3:0];
            valid        = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      phase_d    = phase_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         phase_d    = ~phase_q;
      end
   end

   // enable and the digit select come from the same phase flop, so they
   // always switch together.
   always_comb begin
      if (phase_q == PHASE_TENS) begin
         enable      = 2'b10;
         shown_digit = digit_tens_q;
`ifdef LEADING_ZERO_BLANK_EN
         // Non-BCD code: the decoder turns it into a blank digit.
         if (digit_tens_q == 4'd0) shown_digit = 4'hF;
`endif
      end else begin
         enable      = 2'b01;
         shown_digit = digit_ones_q;
      end
   end

   seg7_decoder u_seg7_decoder (
      .bcd (shown_digit),
      .seg (seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         edge_q       <= 1'b0;
         gate_cnt_q   <= '0;
         edge_cnt_q   <= '0;
         ovf_q        <= 1'b0;
         freq_bin_q   <= '0;
         overflow_q   <= 1'b0;
         state_q      <= IDLE;
         rem_q        <= '0;
         tens_q       <= '0;
         digit_ones_q <= '0;
         digit_tens_q <= '0;
         scan_cnt_q   <= '0;
         phase_q      <= PHASE_ONES;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         sync3_q      <= sync3_d;
         edge_q       <= edge_d;
         gate_cnt_q   <= gate_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         ovf_q        <= ovf_d;
         freq_bin_q   <= freq_bin_d;
         overflow_q   <= overflow_d;
         state_q      <= state_d;
         rem_q        <= rem_d;
         tens_q       <= tens_d;
         digit_ones_q <= digit_ones_d;
         digit_tens_q <= digit_tens_d;
         scan_cnt_q   <= scan_cnt_d;
         phase_q      <= phase_d;
      end
   end

   assign bus.display  = seg;
   assign bus.enable   = enable;
   assign bus.valid    = valid;
   assign bus.overflow = overflow_q;
   assign bus.freq_bin = freq_bin_q;

endmodule

// File: tb/tb_freq_meter_2d.sv
// Testbench for freq_meter_2d with GATE_CYCLES=200, SCAN_DIV=4.
// A per-cycle sig_in pattern is played into the DUT; the reference model
// bins every rising transition into its gate window (input change after
// clock edge j is counted 3 cycles later, in window (j+3)/200) and derives
// the expected freq_bin, overflow, BCD digits and valid latency arithmetically.
module tb_freq_meter_2d;

   localparam int G    = 200;
   localparam int SD   = 4;
   localparam int MAXC = 1300;
   localparam int NW   = 6;

   localparam logic [6:0] SEGREF [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   freq_meter_2d_if bus ();

   freq_meter_2d #(
      .CLK_HZ      (27_000_000),
      .GATE_CYCLES (G),
      .SCAN_DIV    (SD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc;
   bit pat [MAXC];
   int exp_cnt [NW];
   logic [6:0] obs_fb [NW];
   logic       obs_ovf [NW];
   logic [6:0] ones_seg [NW];
   logic [6:0] tens_seg [NW];
   int valid_n [NW];
   int valid_lat [NW];
   int bad_en;
   int stray_valid;

   function automatic int exp_val(input int w);
      return (exp_cnt[w] > 99) ? 99 : exp_cnt[w];
   endfunction

   function automatic logic [6:0] exp_tens_seg(input int v);
`ifdef LEADING_ZERO_BLANK_EN
      if (v / 10 == 0) return 7'b0000000;
`endif
      return SEGREF[v / 10];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_pat();
      for (int i = 0; i < MAXC; i++) pat[i] = 1'b0;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      bus.sig_in = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      bad_en = 0;
      stray_valid = 0;
      for (int i = 0; i < NW; i++) begin
         exp_cnt[i]   = 0;
         obs_fb[i]    = 7'bx;
         obs_ovf[i]   = 1'bx;
         ones_seg[i]  = 7'bx;
         tens_seg[i]  = 7'bx;
         valid_n[i]   = 0;
         valid_lat[i] = -1;
      end
   endtask

   // Drives the pattern, updates the model and records observations.
   task automatic play(input int n);
      int w;
      for (int k = 0; k < n; k++) begin
         if (pat[cyc] && !bus.sig_in && ((cyc + 3) / G < NW)) exp_cnt[(cyc + 3) / G]++;
         bus.sig_in = pat[cyc];
         tick();
         if (bus.enable !== 2'b01 && bus.enable !== 2'b10) bad_en++;
         if (cyc < G) begin
            if (bus.valid !== 1'b0) stray_valid++;
         end else begin
            w = cyc / G - 1;
            if (w < NW) begin
               if (cyc % G == 0) begin
                  obs_fb[w]  = bus.freq_bin;
                  obs_ovf[w] = bus.overflow;
               end
               if (bus.valid === 1'b1) begin
                  valid_n[w]++;
                  valid_lat[w] = cyc - (G * (w + 1) - 1);
               end
               if (cyc % G >= 100 && cyc % G < 116) begin
                  if (bus.enable === 2'b01) ones_seg[w] = bus.display;
                  else if (bus.enable === 2'b10) tens_seg[w] = bus.display;
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      int scan_bad;
      logic [1:0] exp_en;
      apply_reset(3);
      checks++; if (bus.enable !== 2'b01) begin failures++; $display("FAIL reset_enable: got %b expected 01", bus.enable); end
      checks++; if (bus.display !== 7'b1111110) begin failures++; $display("FAIL reset_display: got %b expected 1111110", bus.display); end
      checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
      checks++; if (bus.freq_bin !== 7'd0) begin failures++; $display("FAIL reset_freq_bin: got %0d expected 0", bus.freq_bin); end
      scan_bad = 0;
      for (int k = 0; k < 16; k++) begin
         exp_en = ((k / SD) % 2 == 1) ? 2'b10 : 2'b01;
         if (bus.enable !== exp_en) scan_bad++;
         tick();
      end
      checks++; if (scan_bad != 0) begin failures++; $display("FAIL scan_sequence: got %0d wrong cycles expected 0", scan_bad); end
   endtask

   task automatic test_42hz();
      int start;
      apply_reset(2);
      clear_pat();
      start = G + int'($urandom_range(0, 20));
      for (int i = 0; i < 42; i++) begin
         pat[start + 4 * i]     = 1'b1;
         pat[start + 4 * i + 1] = 1'b1;
      end
      play(2 * G + 120);
      checks++; if (obs_fb[0] !== 7'(exp_val(0))) begin failures++; $display("FAIL f42_fb_w0: got %0d expected %0d", obs_fb[0], exp_val(0)); end
      checks++; if (obs_fb[1] !== 7'(exp_val(1))) begin failures++; $display("FAIL f42_fb_w1: got %0d expected %0d", obs_fb[1], exp_val(1)); end
      checks++; if (obs_ovf[1] !== 1'b0) begin failures++; $display("FAIL f42_ovf: got %b expected 0", obs_ovf[1]); end
      checks++; if (valid_n[1] != 1) begin failures++; $display("FAIL f42_valid_count: got %0d expected 1", valid_n[1]); end
      checks++; if (valid_lat[1] != exp_val(1) / 10 + 2) begin failures++; $display("FAIL f42_valid_latency: got %0d expected %0d", valid_lat[1], exp_val(1) / 10 + 2); end
      checks++; if (ones_seg[1] !== SEGREF[exp_val(1) % 10]) begin failures++; $display("FAIL f42_ones: got %b expected %b", ones_seg[1], SEGREF[exp_val(1) % 10]); end
      checks++; if (tens_seg[1] !== exp_tens_seg(exp_val(1))) begin failures++; $display("FAIL f42_tens: got %b expected %b", tens_seg[1], exp_tens_seg(exp_val(1))); end
      checks++; if (bad_en != 0 || stray_valid != 0) begin failures++; $display("FAIL f42_enable_or_stray: got %0d/%0d expected 0/0", bad_en, stray_valid); end
   endtask

   task automatic test_overflow();
      apply_reset(2);
      for (int c = 0; c < MAXC; c++) pat[c] = (c % 2 == 1);
      play(2 * G + 120);
      checks++; if (obs_fb[0] !== 7'(exp_val(0))) begin failures++; $display("FAIL ovf_fb_w0: got %0d expected %0d", obs_fb[0], exp_val(0)); end
      checks++; if (obs_ovf[0] !== (exp_cnt[0] > 99)) begin failures++; $display("FAIL ovf_flag_w0: got %b expected %b", obs_ovf[0], exp_cnt[0] > 99); end
      checks++; if (obs_fb[1] !== 7'(exp_val(1))) begin failures++; $display("FAIL ovf_fb_w1: got %0d expected %0d", obs_fb[1], exp_val(1)); end
      checks++; if (obs_ovf[1] !== (exp_cnt[1] > 99)) begin failures++; $display("FAIL ovf_flag_w1: got %b expected %b", obs_ovf[1], exp_cnt[1] > 99); end
      checks++; if (valid_lat[1] != exp_val(1) / 10 + 2) begin failures++; $display("FAIL ovf_valid_latency: got %0d expected %0d", valid_lat[1], exp_val(1) / 10 + 2); end
      checks++; if (ones_seg[1] !== SEGREF[exp_val(1) % 10]) begin failures++; $display("FAIL ovf_ones: got %b expected %b", ones_seg[1], SEGREF[exp_val(1) % 10]); end
      checks++; if (tens_seg[1] !== exp_tens_seg(exp_val(1))) begin failures++; $display("FAIL ovf_tens: got %b expected %b", tens_seg[1], exp_tens_seg(exp_val(1))); end
   endtask

   task automatic test_boundary();
      for (int s = 0; s < 2; s++) begin
         apply_reset(2);
         clear_pat();
         // s=0: last detected edge on the gate_end cycle; s=1: one cycle later
         for (int i = 0; i < 4; i++) begin
            pat[184 + s + 4 * i]     = 1'b1;
            pat[184 + s + 4 * i + 1] = 1'b1;
         end
         play(2 * G + 20);
         checks++; if (obs_fb[0] !== 7'(exp_val(0))) begin failures++; $display("FAIL boundary%0d_fb_w0: got %0d expected %0d", s, obs_fb[0], exp_val(0)); end
         checks++; if (obs_fb[1] !== 7'(exp_val(1))) begin failures++; $display("FAIL boundary%0d_fb_w1: got %0d expected %0d", s, obs_fb[1], exp_val(1)); end
         if (s == 0) begin
            checks++; if (ones_seg[0] !== SEGREF[exp_val(0) % 10]) begin failures++; $display("FAIL boundary_ones: got %b expected %b", ones_seg[0], SEGREF[exp_val(0) % 10]); end
            checks++; if (tens_seg[0] !== exp_tens_seg(exp_val(0))) begin failures++; $display("FAIL boundary_tens: got %b expected %b", tens_seg[0], exp_tens_seg(exp_val(0))); end
         end
      end
   endtask

   task automatic test_reset_conv();
      int nv;
      logic [6:0] d_ones, d_tens;
      int start;
      apply_reset(2);
      for (int c = 0; c < MAXC; c++) pat[c] = (c % 2 == 1);
      play(2 * G + 2);
      // now in gate_end+3 of the window holding 100 edges (conversion running)
      apply_reset(2);
      clear_pat();
      start = G + int'($urandom_range(0, 20));
      for (int i = 0; i < 42; i++) begin
         pat[start + 4 * i]     = 1'b1;
         pat[start + 4 * i + 1] = 1'b1;
      end
      play(15);
      nv = 0;
      d_ones = 7'bx;
      d_tens = 7'bx;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (bus.valid !== 1'b0) nv++;
         if (bus.enable === 2'b01) d_ones = bus.display;
         else if (bus.enable === 2'b10) d_tens = bus.display;
      end
      checks++; if (nv + stray_valid != 0) begin failures++; $display("FAIL rstconv_no_valid: got %0d pulses expected 0", nv + stray_valid); end
      checks++; if (d_ones !== SEGREF[0]) begin failures++; $display("FAIL rstconv_ones: got %b expected %b", d_ones, SEGREF[0]); end
      checks++; if (d_tens !== exp_tens_seg(0)) begin failures++; $display("FAIL rstconv_tens: got %b expected %b", d_tens, exp_tens_seg(0)); end
      checks++; if (bus.freq_bin !== 7'd0 || bus.overflow !== 1'b0) begin failures++; $display("FAIL rstconv_fb_ovf: got %0d/%b expected 0/0", bus.freq_bin, bus.overflow); end
      play(2 * G + 120 - cyc);
      checks++; if (obs_fb[1] !== 7'(exp_val(1))) begin failures++; $display("FAIL rstconv_next_fb: got %0d expected %0d", obs_fb[1], exp_val(1)); end
      checks++; if (valid_n[1] != 1 || valid_lat[1] != exp_val(1) / 10 + 2) begin failures++; $display("FAIL rstconv_next_valid: got n=%0d lat=%0d expected n=1 lat=%0d", valid_n[1], valid_lat[1], exp_val(1) / 10 + 2); end
      checks++; if (ones_seg[1] !== SEGREF[exp_val(1) % 10] || tens_seg[1] !== exp_tens_seg(exp_val(1))) begin failures++; $display("FAIL rstconv_next_digits: got %b/%b expected %b/%b", tens_seg[1], ones_seg[1], exp_tens_seg(exp_val(1)), SEGREF[exp_val(1) % 10]); end
   endtask

   task automatic test_random();
      int maxrun, runleft, v;
      bit level;
      for (int it = 0; it < 3; it++) begin
         apply_reset(2);
         maxrun  = (it == 0) ? 2 : ((it == 1) ? 5 : 30);
         level   = 1'b0;
         runleft = int'($urandom_range(1, 10));
         for (int c = 0; c < MAXC; c++) begin
            if (runleft == 0) begin
               level   = ~level;
               runleft = int'($urandom_range(1, maxrun));
            end
            pat[c] = level;
            runleft--;
         end
         play(5 * G + 120);
         for (int w = 0; w < 5; w++) begin
            v = exp_val(w);
            checks++; if (obs_fb[w] !== 7'(v)) begin failures++; $display("FAIL rand%0d_fb_w%0d: got %0d expected %0d", it, w, obs_fb[w], v); end
            checks++; if (obs_ovf[w] !== (exp_cnt[w] > 99)) begin failures++; $display("FAIL rand%0d_ovf_w%0d: got %b expected %b", it, w, obs_ovf[w], exp_cnt[w] > 99); end
            checks++; if (valid_n[w] != 1) begin failures++; $display("FAIL rand%0d_valid_n_w%0d: got %0d expected 1", it, w, valid_n[w]); end
            checks++; if (valid_lat[w] != v / 10 + 2) begin failures++; $display("FAIL rand%0d_lat_w%0d: got %0d expected %0d", it, w, valid_lat[w], v / 10 + 2); end
            checks++; if (ones_seg[w] !== SEGREF[v % 10]) begin failures++; $display("FAIL rand%0d_ones_w%0d: got %b expected %b", it, w, ones_seg[w], SEGREF[v % 10]); end
            checks++; if (tens_seg[w] !== exp_tens_seg(v)) begin failures++; $display("FAIL rand%0d_tens_w%0d: got %b expected %b", it, w, tens_seg[w], exp_tens_seg(v)); end
         end
         checks++; if (bad_en != 0 || stray_valid != 0) begin failures++; $display("FAIL rand%0d_enable_or_stray: got %0d/%0d expected 0/0", it, bad_en, stray_valid); end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.sig_in = 1'b0;
      clear_pat();
      test_reset();
      test_42hz();
      test_overflow();
      test_boundary();
      test_reset_conv();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
